// File: rtl/mem_requester.sv
// Command-FIFO master for the req/wr/memBusy single-port memory protocol.
// Optional busy timeout with rspErr is built only when MEM_TIMEOUT_EN is defined.
module mem_requester #(
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned BUSY_WAIT      = 2,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmdValid,
  output logic              cmdReady,
  input  logic              cmdWr,
  input  logic [ADDR_W-1:0] cmdAddr,
  input  logic [DATA_W-1:0] cmdData,
  output logic              rspValid,
  output logic [DATA_W-1:0] rspData,
  output logic              rspErr,
  output logic              req,
  output logic              wr,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memDataIn,
  input  logic              memBusy,
  input  logic [DATA_W-1:0] memDataOut,
  output logic              idle
);

  localparam int unsigned PtrW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned WcntW = ($clog2(BUSY_WAIT + 1) > 0) ? $clog2(BUSY_WAIT + 1) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWaitBusy,
    StWaitDone,
    StResp
  } state_e;

  state_e state_q, state_d;

  // Command FIFO
  logic              fifo_wr_q   [FIFO_DEPTH];
  logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              push, pop, empty;

  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [WcntW-1:0]  wcnt_q, wcnt_d;

  assign empty = (count_q == '0);
  // Ready is registered, so it never admits a push while the FIFO is full.
  assign push  = cmdValid && cmd_ready_q;
  assign pop   = (state_q == StIdle) && !empty;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    count_d     = count_q + CntW'(push) - CntW'(pop);
    cmd_ready_d = (count_d != CntW'(FIFO_DEPTH));
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_wr_q[wr_ptr_q]   <= cmdWr;
      fifo_addr_q[wr_ptr_q] <= cmdAddr;
      fifo_data_q[wr_ptr_q] <= cmdData;
    end
  end

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned TcntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TcntW-1:0] tcnt_q, tcnt_d;
  logic             rsp_err_q, rsp_err_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d    = state_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    data_d     = data_q;
    rsp_data_d = rsp_data_q;
    wcnt_d     = wcnt_q;
`ifdef MEM_TIMEOUT_EN
    tcnt_d     = tcnt_q;
    rsp_err_d  = rsp_err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          wr_d    = fifo_wr_q[rd_ptr_q];
          addr_d  = fifo_addr_q[rd_ptr_q];
          data_d  = fifo_data_q[rd_ptr_q];
          state_d = StIssue;
        end
      end
      StIssue: begin
        wcnt_d  = '0;
        state_d = StWaitBusy;
      end
      StWaitBusy: begin
        if (memBusy) begin
          state_d = StWaitDone;
`ifdef MEM_TIMEOUT_EN
          tcnt_d  = '0;
`endif
        end else begin
          // Memory never signalled busy: treat the access as already complete.
          wcnt_d = wcnt_q + WcntW'(1);
          if (wcnt_d == WcntW'(BUSY_WAIT)) begin
            rsp_data_d = wr_q ? '0 : memDataOut;
`ifdef MEM_TIMEOUT_EN
            rsp_err_d  = 1'b0;
`endif
            state_d    = StResp;
          end
        end
      end
      StWaitDone: begin
        if (!memBusy) begin
          rsp_data_d = wr_q ? '0 : memDataOut;
`ifdef MEM_TIMEOUT_EN
          rsp_err_d  = 1'b0;
`endif
          state_d    = StResp;
        end
`ifdef MEM_TIMEOUT_EN
        else begin
          tcnt_d = tcnt_q + TcntW'(1);
          if (tcnt_d == TcntW'(TIMEOUT_CYCLES)) begin
            rsp_data_d = '0;
            rsp_err_d  = 1'b1;
            state_d    = StResp;
          end
        end
`endif
      end
      StResp: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      cmd_ready_q <= 1'b1;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      rsp_data_q  <= '0;
      wcnt_q      <= '0;
`ifdef MEM_TIMEOUT_EN
      tcnt_q      <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      cmd_ready_q <= cmd_ready_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      rsp_data_q  <= rsp_data_d;
      wcnt_q      <= wcnt_d;
`ifdef MEM_TIMEOUT_EN
      tcnt_q      <= tcnt_d;
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  assign cmdReady  = cmd_ready_q;
  assign req       = (state_q == StIssue);
  assign rspValid  = (state_q == StResp);
  assign rspData   = rsp_data_q;
  assign wr        = wr_q;
  assign memAddr   = addr_q;
  assign memDataIn = data_q;
  assign idle      = empty && (state_q == StIdle) && !push;
`ifdef MEM_TIMEOUT_EN
  assign rspErr    = rsp_err_q;
`else
  assign rspErr    = 1'b0;
`endif

endmodule

// File: tb/tb_mem_requester.sv
// Directed bench for mem_requester: behavioural memory, request/response scoreboards.
// Timeout checks run only when MEM_TIMEOUT_EN is defined.
module tb_mem_requester;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              cmdValid = 1'b0;
  logic              cmdReady;
  logic              cmdWr = 1'b0;
  logic [ADDR_W-1:0] cmdAddr = '0;
  logic [DATA_W-1:0] cmdData = '0;
  logic              rspValid;
  logic [DATA_W-1:0] rspData;
  logic              rspErr;
  logic              req;
  logic              wr;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memDataIn;
  logic              memBusy = 1'b0;
  logic [DATA_W-1:0] memDataOut = '0;
  logic              idle;

  mem_requester dut (
    .clk        (clk),
    .reset      (reset),
    .cmdValid   (cmdValid),
    .cmdReady   (cmdReady),
    .cmdWr      (cmdWr),
    .cmdAddr    (cmdAddr),
    .cmdData    (cmdData),
    .rspValid   (rspValid),
    .rspData    (rspData),
    .rspErr     (rspErr),
    .req        (req),
    .wr         (wr),
    .memAddr    (memAddr),
    .memDataIn  (memDataIn),
    .memBusy    (memBusy),
    .memDataOut (memDataOut),
    .idle       (idle)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  typedef struct packed {logic err; logic [DATA_W-1:0] data;} rsp_t;
  typedef struct packed {logic w; logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data;} req_t;

  rsp_t              exp_rsp[$];
  req_t              exp_req[$];
  logic [DATA_W-1:0] shadow  [256];
  logic [DATA_W-1:0] sim_mem [256];

  // Memory model knobs and state
  int   busy_len = 1;
  bit   stuck = 1'b0;
  int   busy_left = 0;
  bit   active = 1'b0;
  bit   prev_req = 1'b0;
  req_t cur;
  req_t er;
  int   req_count = 0;

  always @(negedge clk) begin : mem_model
    if (!reset) begin
      memBusy  = 1'b0;
      active   = 1'b0;
      prev_req = 1'b0;
    end else begin
      if (req) begin
        chk("req_single_cycle", 64'(prev_req), 64'd0);
        req_count++;
        chk("req_expected", 64'(exp_req.size() > 0), 64'd1);
        if (exp_req.size() > 0) begin
          er = exp_req.pop_front();
          chk("req_wr", 64'(wr), 64'(er.w));
          chk("req_addr", 64'(memAddr), 64'(er.addr));
          if (er.w) chk("req_data", 64'(memDataIn), 64'(er.data));
        end
        cur = {wr, memAddr, memDataIn};
        if (wr) sim_mem[memAddr] = memDataIn;
        if (stuck || busy_len > 0) begin
          memBusy    = 1'b1;
          busy_left  = busy_len;
          active     = 1'b1;
          memDataOut = 32'hDEAD_BEEF;
        end else begin
          memDataOut = sim_mem[memAddr];
        end
      end else if (active) begin
        chk("hold_addr", 64'(memAddr), 64'(cur.addr));
        chk("hold_data", 64'(memDataIn), 64'(cur.data));
        chk("hold_wr", 64'(wr), 64'(cur.w));
        if (!stuck) begin
          if (busy_left == 0) begin
            memBusy    = 1'b0;
            active     = 1'b0;
            memDataOut = sim_mem[cur.addr];
          end else begin
            busy_left--;
          end
        end
      end
      prev_req = req;
    end
  end

  int   rsp_count = 0;
  int   last_rsp_cyc = 0;
  rsp_t er_rsp;

  always @(negedge clk) begin : rsp_monitor
    if (reset && rspValid) begin
      rsp_count++;
      last_rsp_cyc = cyc;
      chk("rsp_expected", 64'(exp_rsp.size() > 0), 64'd1);
      if (exp_rsp.size() > 0) begin
        er_rsp = exp_rsp.pop_front();
        chk("rsp_data", 64'(rspData), 64'(er_rsp.data));
        chk("rsp_err", 64'(rspErr), 64'(er_rsp.err));
      end
    end
  end

  int acc_cyc = 0;

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send(input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bit done = 1'b0;
    int n = 0;
    cmdValid = 1'b1;
    cmdWr    = w;
    cmdAddr  = a;
    cmdData  = d;
    while (!done && n < 200) begin
      if (cmdReady) begin
        done    = 1'b1;
        acc_cyc = cyc;
      end
      @(negedge clk);
      n++;
    end
    cmdValid = 1'b0;
    chk("send_accepted", 64'(done), 64'd1);
    if (done) begin
      exp_req.push_back({w, a, d});
      exp_rsp.push_back({1'b0, (w ? 32'h0 : shadow[a])});
      if (w) shadow[a] = d;
    end
  endtask

  task automatic wait_drain(input string tag, input int limit);
    int n = 0;
    while ((exp_rsp.size() != 0 || !idle) && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(exp_rsp.size()), 64'd0);
    chk({tag, "_idle"}, 64'(idle), 64'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"}, 64'(req), 64'd0);
    chk({tag, "_wr"}, 64'(wr), 64'd0);
    chk({tag, "_addr"}, 64'(memAddr), 64'd0);
    chk({tag, "_wdata"}, 64'(memDataIn), 64'd0);
    chk({tag, "_rspvalid"}, 64'(rspValid), 64'd0);
    chk({tag, "_rspdata"}, 64'(rspData), 64'd0);
    chk({tag, "_rsperr"}, 64'(rspErr), 64'd0);
    chk({tag, "_ready"}, 64'(cmdReady), 64'd1);
    chk({tag, "_idle"}, 64'(idle), 64'd1);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  int base_rsp, base_req, t5, rc;

  initial begin : stim
    for (int i = 0; i < 256; i++) begin
      shadow[i]  = '0;
      sim_mem[i] = '0;
    end

    // Reset held low two cycles
    repeat (2) @(negedge clk);
    chk_reset_outputs("in_reset");
    reset = 1'b1;
    @(negedge clk);
    chk_reset_outputs("after_reset");

    // Writes, one busy cycle each
    busy_len = 1;
    base_rsp = rsp_count;
    base_req = req_count;
    for (int i = 0; i < 15; i++) send(1'b1, ADDR_W'(i), 32'h1000 + 32'(i));
    wait_drain("wr_drain", 400);
    chk("wr_rsp_count", 64'(rsp_count - base_rsp), 64'd15);
    chk("wr_req_count", 64'(req_count - base_req), 64'd15);

    // Read back
    base_rsp = rsp_count;
    for (int i = 0; i < 15; i++) send(1'b0, ADDR_W'(i), 32'h0);
    wait_drain("rd_drain", 400);
    chk("rd_rsp_count", 64'(rsp_count - base_rsp), 64'd15);

    // FIFO fill with long busy: first is popped at once, then four are stored
    busy_len = 10;
    base_rsp = rsp_count;
    for (int i = 0; i < 5; i++) send(1'b0, ADDR_W'(i + 2), 32'h0);
    chk("full_ready", 64'(cmdReady), 64'd0);
    chk("full_not_idle", 64'(idle), 64'd0);
    t5 = acc_cyc;
    send(1'b1, 8'd40, 32'hCAFE_0040);
    chk("sixth_stalled", 64'((acc_cyc - t5) > 10), 64'd1);
    wait_drain("full_drain", 400);
    chk("full_rsp_count", 64'(rsp_count - base_rsp), 64'd6);

    // Memory never raises busy
    busy_len = 0;
    send(1'b0, 8'd3, 32'h0);
    wait_drain("nobusy_rd", 100);
    chk("nobusy_latency", 64'(last_rsp_cyc - acc_cyc), 64'd5);
    send(1'b1, 8'd50, 32'h5555_AAAA);
    wait_drain("nobusy_wr", 100);
    chk("nobusy_wr_latency", 64'(last_rsp_cyc - acc_cyc), 64'd5);
    send(1'b0, 8'd50, 32'h0);
    wait_drain("nobusy_rdback", 100);

    // Reset in the middle of WAIT_DONE discards the command
    busy_len = 20;
    send(1'b0, 8'd7, 32'h0);
    repeat (5) @(negedge clk);
    chk("pre_reset_busy", 64'(memBusy), 64'd1);
    #2 reset = 1'b0;
    #1;
    chk_reset_outputs("mid_reset");
    exp_rsp.delete();
    exp_req.delete();
    rc = rsp_count;
    base_req = req_count;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (30) @(negedge clk);
    chk("no_rsp_after_reset", 64'(rsp_count), 64'(rc));
    chk("no_req_after_reset", 64'(req_count), 64'(base_req));
    chk("idle_after_reset", 64'(idle), 64'd1);

`ifdef MEM_TIMEOUT_EN
    // Busy stuck high: timeout response
    busy_len = 0;
    stuck    = 1'b1;
    send(1'b0, 8'd9, 32'h0);
    void'(exp_rsp.pop_back());
    exp_rsp.push_back({1'b1, 32'h0});
    wait_drain("timeout_drain", 200);
    chk("timeout_latency", 64'(last_rsp_cyc - acc_cyc), 64'd68);
    stuck = 1'b0;
    repeat (3) @(negedge clk);
    chk("timeout_busy_released", 64'(memBusy), 64'd0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
